// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// The fairness feature is enabled by defining DMEM_ARB_FAIRNESS_EN.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        S_PIPE      = 2'd0,
        S_DBG_ISSUE = 2'd1,
        S_DBG_WAIT  = 2'd2,
        S_DBG_RESP  = 2'd3
    } state_t;

    localparam logic [3:0]  WE_ALL         = 4'b1111;
    localparam int unsigned STARVE_MAX_DEF = 8;

    // Byte address to word address; callers keep the low ADDR_W bits.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

endpackage

// File: rtl/dmem_arb_age_counter.sv
// Saturating age counter for a waiting debug request; clear has priority over increment.
// Only instantiated when DMEM_ARB_FAIRNESS_EN is defined.
module dmem_arb_age_counter #(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned W = $clog2(STARVE_MAX + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (inc && !at_max) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign at_max = (cnt_q == W'(STARVE_MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (priority) and the debug unit.
// Optional fairness guard against debug starvation: define DMEM_ARB_FAIRNESS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned B          = 32,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [B-1:0]      pipe_addr,
    input  logic [B-1:0]      pipe_wdata,
    input  logic              pipe_halt,
    output logic              pipe_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [B-1:0]      dbg_addr,
    input  logic [B-1:0]      dbg_wdata,
    output logic              dbg_ack,
    output logic [B-1:0]      dbg_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [B-1:0]      mem_wdata,
    input  logic [B-1:0]      mem_rdata
);

    // Last value of the wait counter before the read data is due.
    localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t              state_q, state_d;
    logic [1:0]          wait_q, wait_d;
    logic                dbg_we_q;
    logic [ADDR_W-1:0]   dbg_addr_q;
    logic [B-1:0]        dbg_wdata_q;
    logic [B-1:0]        dbg_rdata_q;
    logic [ADDR_W-1:0]   pipe_word;
    logic [ADDR_W-1:0]   dbg_word;
    logic                preq;
    logic                force_req;
    logic                force_act;
    logic                grant_dbg;

    assign preq      = pipe_req & ~pipe_halt;
    assign force_act = force_req & dbg_req;
    assign grant_dbg = (state_q == S_PIPE) & dbg_req & (~preq | force_req);
    assign pipe_word = ADDR_W'(word_addr(32'(pipe_addr)));
    assign dbg_word  = ADDR_W'(word_addr(32'(dbg_addr)));

`ifdef DMEM_ARB_FAIRNESS_EN
    dmem_arb_age_counter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_age_counter (
        .clk   (clk),
        .reset (reset),
        .inc   ((state_q == S_PIPE) & dbg_req & preq),
        .clr   (grant_dbg),
        .at_max(force_req)
    );
`else
    assign force_req = 1'b0;
`endif

    assign pipe_stall = preq & ((state_q != S_PIPE) | force_act);
    assign dbg_ack    = (state_q == S_DBG_RESP);
    // Read data goes straight through during the ack cycle, then the captured copy is held.
    assign dbg_rdata  = (dbg_ack && !dbg_we_q) ? mem_rdata : dbg_rdata_q;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = dbg_addr_q;
        mem_wdata = dbg_wdata_q;
        unique case (state_q)
            S_PIPE: begin
                mem_addr  = pipe_word;
                mem_wdata = pipe_wdata;
                mem_en    = preq & ~force_act;
                mem_we    = {4{preq & pipe_we & ~force_act}};
                if (grant_dbg) begin
                    state_d = S_DBG_ISSUE;
                end
            end
            S_DBG_ISSUE: begin
                mem_en  = 1'b1;
                mem_we  = dbg_we_q ? WE_ALL : 4'b0000;
                wait_d  = 2'd0;
                state_d = (dbg_we_q || RD_LAT <= 1) ? S_DBG_RESP : S_DBG_WAIT;
            end
            S_DBG_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_DBG_RESP;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_DBG_RESP: begin
                state_d = S_PIPE;
            end
            default: begin
                state_d = S_PIPE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_PIPE;
            wait_q      <= 2'd0;
            dbg_we_q    <= 1'b0;
            dbg_addr_q  <= '0;
            dbg_wdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (grant_dbg) begin
                dbg_we_q    <= dbg_we;
                dbg_addr_q  <= dbg_word;
                dbg_wdata_q <= dbg_wdata;
            end
            if (state_q == S_DBG_RESP && !dbg_we_q) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

endmodule
